dev_output_bank: RTL and testbench
==================================

Name: dev_output_bank

Overview:
Parametrised multi-channel output device on the CPU device bus, successor to the two-slot output register.
- NUM_CH channels; each holds a current and a previous (shadow) value.
- Byte-enabled writes and per-channel sticky change flags.
- Built-in scan sequencer that time-multiplexes channels onto one display port (e.g. LED/7-seg driver).

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
NUM_CH, 4, number of output channels; 2..16
ADDR_W, 2, channel address width; NUM_CH <= 2**ADDR_W
BAD_VAL, 32'h11111111, read value for out-of-range addresses (truncated/zero-extended to DATA_W)

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  bus write strobe
addr  in  ADDR_W  channel index for read and write
be  in  DATA_W/8  byte enables; be[i] covers wdata[8i+7:8i]
wdata  in  DATA_W  write data
rsel  in  1  read select: 0 = current, 1 = previous
rdata  out  DATA_W  combinational read data
changed  out  NUM_CH  sticky per-channel "value changed" flags
clr_chg  in  NUM_CH  per-channel flag clear strobes
scan_en  in  1  scan sequencer enable
scan_div  in  16  scan period minus one, in clk cycles
scan_ch  out  ADDR_W  channel currently presented on the scan port
scan_data  out  DATA_W  current value of channel scan_ch (combinational)
scan_tick  out  1  one-cycle registered pulse when scan_ch advances

Behaviour:
Reset:
- Asserting rst clears immediately, regardless of clk: all cur/prev registers to 0, changed to 0, divider counter to 0, scan_ch to 0, scan_tick to 0.
- rst takes priority over every other input.

Write, valid when we=1, addr<NUM_CH, be!=0:
- merged = cur[addr] with the enabled bytes replaced by wdata.
- prev[addr] <= cur[addr]; cur[addr] <= merged.
- changed[addr] <= 1 only if merged != cur[addr].

Ignored writes:
- we=1 with be==0: no state change, no shift into prev.
- addr>=NUM_CH: write ignored; no channel is touched.

Read:
- Purely combinational.
- addr<NUM_CH: rdata = rsel ? prev[addr] : cur[addr].
- addr>=NUM_CH: rdata = BAD_VAL.
- A write and a read to the same channel in the same cycle returns the pre-write value; the new value is visible from the next cycle.

Change flags:
- clr_chg[i] clears changed[i] on the next edge.
- A set and a clear on the same channel in the same cycle: set wins.

Scan sequencer:
- scan_en=0: divider counter and scan_ch hold; scan_tick=0.
- scan_en=1: counter increments each cycle.
- When counter >= scan_div:
  - counter <= 0;
  - scan_ch <= (scan_ch==NUM_CH-1) ? 0 : scan_ch+1;
  - scan_tick <= 1 for exactly one cycle.
- scan_div=0 advances scan_ch every cycle, with scan_tick held high continuously.
- Lowering scan_div below the current count mid-period wraps on the next cycle (>= compare).
- scan_ch never reaches a value >= NUM_CH.
- scan_data tracks cur[scan_ch], so a write to the scanned channel appears on scan_data the cycle after the write.

Test Plan:
- Reset then read: rst pulse mid-run -> all rdata 0 for rsel 0/1, changed=0, scan_ch=0, scan_tick=0 immediately, without waiting for a clk edge.
- Byte-enable merge: write ch1 32'hAABBCCDD be=4'hF, then 32'h00001122 be=4'h3 -> rsel=0 reads 32'hAABB1122, rsel=1 reads 32'hAABBCCDD, changed[1]=1.
- No-op writes: be=0 write to ch2, and write to addr=3 with NUM_CH=3 -> ch2 unchanged, prev unchanged, changed=0; reading addr=3 returns 32'h11111111.
- Change flags: rewrite an identical value -> changed stays 0 after a clear; same-cycle write-with-change plus clr_chg[0] -> changed[0]=1.
- Scan timing: NUM_CH=4, scan_div=2, scan_en=1 -> scan_ch sequence 0,1,2,3,0 with a 3-cycle period and a single-cycle scan_tick per step; scan_en=0 freezes scan_ch; scan_div=0 -> scan_ch changes every cycle.
- Scan/write interaction: write ch0 while scan_ch=0 -> scan_data shows the new value one cycle later; async rst mid-period -> counter and scan_ch return to 0 immediately.

Source files
------------

// File: rtl/dev_output_bank_if.sv
// CPU device-bus port of the multi-channel output bank: write strobe, byte-enabled
// data and a combinational read-back path selecting the current or shadow value.
interface dev_output_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     wdata;
  logic                  rsel;
  logic [DATA_W-1:0]     rdata;

  modport master (output we, addr, be, wdata, rsel, input rdata);
  modport slave  (input we, addr, be, wdata, rsel, output rdata);
endinterface

// File: rtl/dev_output_bank.sv
// Multi-channel output register bank with shadow values, sticky change flags and a
// scan sequencer that time-multiplexes the channels onto a single display port.
module dev_output_bank #(
  parameter int DATA_W  = 32,  // multiple of 8
  parameter int NUM_CH  = 4,   // 2..16, NUM_CH <= 2**ADDR_W
  parameter int ADDR_W  = 2,
  parameter     BAD_VAL = 32'h11111111
) (
  input  logic                clk,
  input  logic                rst,
  dev_output_bank_if.slave    bus,
  output logic [NUM_CH-1:0]   changed,
  input  logic [NUM_CH-1:0]   clr_chg,
  input  logic                scan_en,
  input  logic [15:0]         scan_div,
  output logic [ADDR_W-1:0]   scan_ch,
  output logic [DATA_W-1:0]   scan_data,
  output logic                scan_tick
);

  localparam int                NB         = DATA_W / 8;
  localparam logic [ADDR_W:0]   NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);
  localparam logic [ADDR_W-1:0] LAST_CH    = ADDR_W'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] BAD_WORD   = DATA_W'(BAD_VAL);

  typedef logic [DATA_W-1:0] word_t;

  word_t             cur_q  [NUM_CH];
  word_t             prev_q [NUM_CH];
  logic              addr_ok;
  logic [ADDR_W-1:0] addr_idx;
  word_t             cur_sel;
  word_t             prev_sel;
  word_t             merged;
  logic              wr_en;
  logic              wr_chg;
  logic [NUM_CH-1:0] set_vec;
  logic [15:0]       div_cnt;
  logic              wrap;

  // Out-of-range addresses are steered to channel 0 so no array index ever leaves
  // the bank; addr_ok masks every effect of such an access.
  assign addr_ok  = {1'b0, bus.addr} < NUM_CH_EXT;
  assign addr_idx = addr_ok ? bus.addr : '0;
  assign cur_sel  = cur_q[addr_idx];
  assign prev_sel = prev_q[addr_idx];

  // NOTE: every variable driven here gets a default before any conditional update,
  // otherwise a byte with be=0 would have no assignment and infer a latch.
  always_comb begin
    merged = cur_sel;
    for (int b = 0; b < NB; b++) begin
      if (bus.be[b]) merged[8*b +: 8] = bus.wdata[8*b +: 8];
    end
  end

  assign wr_en   = bus.we && addr_ok && (|bus.be);
  assign wr_chg  = wr_en && (merged != cur_sel);
  assign set_vec = wr_chg ? (NUM_CH'(1) << addr_idx) : '0;

  // Read path sees the registered values, so a same-cycle write is not forwarded.
  assign bus.rdata = !addr_ok ? BAD_WORD : (bus.rsel ? prev_sel : cur_sel);

  // NOTE: this bank is a handful of flops, not a RAM macro, so every entry is reset;
  // a real RAM array cannot be cleared this way and would need an init sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur_q[i]  <= '0;
        prev_q[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: non-blocking assignments make prev capture the pre-write value of cur.
      prev_q[addr_idx] <= cur_sel;
      cur_q[addr_idx]  <= merged;
    end
  end

  // Clear first, then OR the set vector: a same-cycle set beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed <= '0;
    else     changed <= (changed & ~clr_chg) | set_vec;
  end

  // The >= compare lets a mid-period reduction of scan_div wrap on the next cycle.
  assign wrap = scan_en && (div_cnt >= scan_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      scan_ch   <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= wrap;
      if (scan_en) begin
        if (wrap) begin
          div_cnt <= '0;
          scan_ch <= (scan_ch == LAST_CH) ? '0 : scan_ch + 1'b1;
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end
    end
  end

  assign scan_data = cur_q[scan_ch];

endmodule

// File: tb/tb_dev_output_bank.sv
// Scoreboard bench for dev_output_bank: the driver pushes model predictions per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dev_output_bank;

  localparam int          NCH = 3;
  localparam logic [31:0] BAD = 32'h11111111;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rsel;
    logic [2:0]  clr;
    logic        en;
    logic [15:0] div;
  } stim_t;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  chg;
    logic [1:0]  ch;
    logic        tick;
    logic [31:0] sdata;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] changed;
  logic [NCH-1:0] clr_chg;
  logic           scan_en;
  logic [15:0]    scan_div;
  logic [1:0]     scan_ch;
  logic [31:0]    scan_data;
  logic           scan_tick;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  // Reference model state: channel contents, flags, and the scan position expressed
  // as a count of completed advances plus the cycles spent in the current period.
  logic [31:0] m_cur  [NCH];
  logic [31:0] m_prev [NCH];
  logic [2:0]  m_chg;
  int          m_cnt;
  int          m_steps;
  bit          m_tick;

  dev_output_bank_if #(.DATA_W(32), .ADDR_W(2)) bus ();

  dev_output_bank #(
    .DATA_W(32), .NUM_CH(NCH), .ADDR_W(2), .BAD_VAL(BAD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .changed(changed), .clr_chg(clr_chg),
    .scan_en(scan_en), .scan_div(scan_div),
    .scan_ch(scan_ch), .scan_data(scan_data), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic we, input logic [1:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input logic rsel,
                               input logic [2:0] clr, input logic en, input logic [15:0] div);
    stim_t s;
    s.we = we; s.addr = addr; s.be = be; s.wdata = wdata;
    s.rsel = rsel; s.clr = clr; s.en = en; s.div = div;
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cur[i]  = '0;
      m_prev[i] = '0;
    end
    m_chg = '0; m_cnt = 0; m_steps = 0; m_tick = 0;
  endfunction

  function automatic void model_update(input stim_t s);
    logic [31:0] nv;
    if (s.we && int'(s.addr) < NCH && s.be != 4'h0) begin
      nv = m_cur[s.addr];
      for (int b = 0; b < 4; b++) if (s.be[b]) nv[8*b +: 8] = s.wdata[8*b +: 8];
      m_chg = m_chg & ~s.clr;
      if (nv != m_cur[s.addr]) m_chg[s.addr] = 1'b1;
      m_prev[s.addr] = m_cur[s.addr];
      m_cur[s.addr]  = nv;
    end else begin
      m_chg = m_chg & ~s.clr;
    end
    m_tick = 0;
    if (s.en) begin
      if (m_cnt >= int'(s.div)) begin
        m_cnt = 0; m_steps++; m_tick = 1;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  function automatic void push_expect(input stim_t s);
    exp_t e;
    if (int'(s.addr) < NCH) e.rdata = s.rsel ? m_prev[s.addr] : m_cur[s.addr];
    else                    e.rdata = BAD;
    e.chg   = m_chg;
    e.ch    = 2'(m_steps % NCH);
    e.tick  = m_tick;
    e.sdata = m_cur[m_steps % NCH];
    exp_q.push_back(e);
  endfunction

  task automatic apply(input stim_t s);
    bus.we = s.we; bus.addr = s.addr; bus.be = s.be; bus.wdata = s.wdata;
    bus.rsel = s.rsel; clr_chg = s.clr; scan_en = s.en; scan_div = s.div;
  endtask

  // One clock cycle: drive, predict, then let the edge happen and advance the model.
  task automatic step(input stim_t s);
    apply(s);
    push_expect(s);
    @(posedge clk);
    model_update(s);
    #1;
  endtask

  task automatic do_reset(input stim_t s);
    stim_t q;
    q = s;
    q.we = 1'b0;
    rst = 1'b1;
    apply(q);
    model_reset();
    #1;
    check("rst_async_scan_ch", 32'(scan_ch), 32'h0);
    check("rst_async_changed", 32'(changed), 32'h0);
    push_expect(q);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic read_kat(input logic [1:0] a, input logic rs, input logic [31:0] exp,
                          input string name);
    bus.we = 1'b0; bus.addr = a; bus.rsel = rs;
    #1;
    check(name, bus.rdata, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_rdata",     bus.rdata,        e.rdata);
        check("sb_changed",   32'(changed),     32'(e.chg));
        check("sb_scan_ch",   32'(scan_ch),     32'(e.ch));
        check("sb_scan_tick", 32'(scan_tick),   32'(e.tick));
        check("sb_scan_data", scan_data,        e.sdata);
      end
    end
  end

  initial begin : driver
    stim_t idle;
    stim_t s;
    logic [1:0] ch_before;
    idle = mk(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 3'b000, 1'b0, 16'd0);
    rst = 1'b1;
    apply(idle);
    model_reset();
    @(posedge clk);
    #1;
    do_reset(idle);

    // Byte-enable merge and shadow value
    step(mk(1'b1, 2'd1, 4'hF, 32'hAABBCCDD, 1'b0, 3'b000, 1'b0, 16'd0));
    step(mk(1'b1, 2'd1, 4'h3, 32'h00001122, 1'b0, 3'b000, 1'b0, 16'd0));
    read_kat(2'd1, 1'b0, 32'hAABB1122, "merge_cur");
    read_kat(2'd1, 1'b1, 32'hAABBCCDD, "merge_prev");
    check("merge_changed1", 32'(changed[1]), 32'h1);

    // Clear, then ignored writes
    step(mk(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 3'b111, 1'b0, 16'd0));
    check("flags_cleared", 32'(changed), 32'h0);
    step(mk(1'b1, 2'd2, 4'h0, 32'hDEADBEEF, 1'b0, 3'b000, 1'b0, 16'd0));
    step(mk(1'b1, 2'd3, 4'hF, 32'hCAFEF00D, 1'b0, 3'b000, 1'b0, 16'd0));
    read_kat(2'd2, 1'b0, 32'h0, "noop_cur2");
    read_kat(2'd2, 1'b1, 32'h0, "noop_prev2");
    read_kat(2'd1, 1'b1, 32'hAABBCCDD, "noop_prev1");
    read_kat(2'd3, 1'b0, BAD, "bad_addr");
    check("noop_changed", 32'(changed), 32'h0);

    // Identical rewrite still shifts prev but raises no flag
    step(mk(1'b1, 2'd1, 4'hF, 32'hAABB1122, 1'b0, 3'b000, 1'b0, 16'd0));
    check("same_val_no_chg", 32'(changed), 32'h0);
    read_kat(2'd1, 1'b1, 32'hAABB1122, "same_val_prev");

    // Set beats clear on the same channel
    step(mk(1'b1, 2'd0, 4'hF, 32'h12345678, 1'b0, 3'b001, 1'b0, 16'd0));
    check("set_wins", 32'(changed[0]), 32'h1);

    // Scan period of 3 cycles, wrap at NCH-1
    do_reset(idle);
    for (int i = 1; i <= 9; i++) begin
      step(mk(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 3'b000, 1'b1, 16'd2));
      check("scan_seq_ch", 32'(scan_ch), 32'((i / 3) % NCH));
      check("scan_seq_tick", 32'(scan_tick), (i % 3 == 0) ? 32'h1 : 32'h0);
    end
    step(mk(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 3'b000, 1'b1, 16'd2));
    ch_before = scan_ch;
    for (int i = 0; i < 4; i++) begin
      step(mk(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 3'b000, 1'b0, 16'd2));
      check("scan_freeze_ch", 32'(scan_ch), 32'(ch_before));
      check("scan_freeze_tick", 32'(scan_tick), 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      ch_before = scan_ch;
      step(mk(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 3'b000, 1'b1, 16'd0));
      check("scan_div0_ch", 32'(scan_ch), 32'((int'(ch_before) + 1) % NCH));
      check("scan_div0_tick", 32'(scan_tick), 32'h1);
    end

    // Write to the channel being scanned
    ch_before = scan_ch;
    step(mk(1'b1, ch_before, 4'hF, 32'h5A5A5A5A, 1'b0, 3'b000, 1'b0, 16'd0));
    check("scan_data_write", scan_data, 32'h5A5A5A5A);

    // Async reset in the middle of a long period
    for (int i = 0; i < 6; i++) step(mk(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 3'b000, 1'b1, 16'd50));
    do_reset(idle);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) begin
        s.div = 16'($urandom_range(0, 5));
        s.en  = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 29) == 0) s.div = 16'($urandom_range(0, 5));
      s.we    = ($urandom_range(0, 1) == 1);
      s.addr  = 2'($urandom_range(0, 3));
      s.be    = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      s.wdata = $urandom;
      if (int'(s.addr) < NCH && $urandom_range(0, 99) < 30) s.wdata = m_cur[s.addr];
      s.rsel  = 1'($urandom);
      s.clr   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 199) == 0) do_reset(s);
      else                             step(s);
    end

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
